// File: rtl/rr_select_mux_pkg.sv
// Shared definitions for the round-robin selector and its arbiter.
package rr_select_mux_pkg;

    // Grant-mode encodings for the RR_MODE parameter
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Ceiling log2, floored at 1 so a channel index always has at least one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_select_mux_arbiter.sv
// Combinational N-way arbiter: request vector plus start pointer in,
// one-hot grant and its encoded index out. Shared with other bus arbiters.
module rr_arbiter
    import rr_select_mux_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int RR_MODE = MODE_RR,
    parameter int IDX_W   = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic found;
    int   k;

    // Scan from the pointer (round-robin) or from channel 0 (fixed), wrapping at N_CH
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (RR_MODE == MODE_RR) begin
                k = (int'(ptr) + i) % N_CH;
            end else begin
                k = i;
            end
            if (!found && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
                found     = 1'b1;
            end
        end
    end

    assign grant_any = found;

endmodule

// File: rtl/rr_select_mux.sv
// N-channel selector: arbitrates among valid inputs and forwards one word
// per cycle through a registered output stage with valid/ready handshakes.
module rr_select_mux
    import rr_select_mux_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_CH    = 4,
    parameter int RR_MODE = MODE_RR,
    parameter int IDX_W   = clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    hold
);

    logic [N_CH-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic [IDX_W-1:0] ptr_p0;
    logic [IDX_W-1:0] ptr_next;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] data_p1;
    logic [IDX_W-1:0] ch_p1;
    logic             vld_p1;

    rr_arbiter #(
        .N_CH    (N_CH),
        .RR_MODE (RR_MODE),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_p0),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Output slot is free when empty or being drained this cycle
    assign can_load = ~vld_p1 | out_ready;
    assign accept   = can_load & grant_any & rst_n;

    // Only the granted channel sees ready, and nothing is accepted while in reset
    assign in_ready = (can_load && rst_n) ? grant : '0;

    // Next pointer: one past the winner, wrapping explicitly for non-power-of-2 N_CH
    assign ptr_next = (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    // AND-OR data select driven by the one-hot grant
    always_comb begin
        sel_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            sel_data = sel_data | (in_data[c*WIDTH +: WIDTH] & {WIDTH{grant[c]}});
        end
    end

    // ---- stage p0 -> p1: output register (load replaces drain in the same edge) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            ch_p1   <= '0;
            vld_p1  <= 1'b0;
        end else if (accept) begin
            data_p1 <= sel_data;
            ch_p1   <= grant_idx;
            vld_p1  <= 1'b1;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner unless frozen by hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p0 <= '0;
        end else if ((RR_MODE == MODE_RR) && accept && !hold) begin
            ptr_p0 <= ptr_next;
        end
    end

    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_rr_select_mux.sv
// Directed bench for rr_select_mux: a round-robin instance driven from a
// vector table plus hand sequences, and a fixed-priority instance alongside.
module tb_rr_select_mux;

    logic         clk;
    logic         rst_n;

    logic [127:0] rr_data;
    logic [3:0]   rr_valid;
    logic [3:0]   rr_ready;
    logic [31:0]  rr_odata;
    logic [1:0]   rr_och;
    logic         rr_ovalid;
    logic         rr_oready;
    logic         rr_hold;

    logic [127:0] fx_data;
    logic [3:0]   fx_valid;
    logic [3:0]   fx_ready;
    logic [31:0]  fx_odata;
    logic [1:0]   fx_och;
    logic         fx_ovalid;
    logic         fx_oready;
    logic         fx_hold;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  valid;
        logic        oready;
        logic        hold;
        logic [3:0]  exp_ready;
        logic        exp_ovalid;
        logic [1:0]  exp_ch;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    rr_select_mux #(.WIDTH(32), .N_CH(4), .RR_MODE(1), .IDX_W(2)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (rr_data),
        .in_valid  (rr_valid),
        .in_ready  (rr_ready),
        .out_data  (rr_odata),
        .out_ch    (rr_och),
        .out_valid (rr_ovalid),
        .out_ready (rr_oready),
        .hold      (rr_hold)
    );

    rr_select_mux #(.WIDTH(32), .N_CH(4), .RR_MODE(0), .IDX_W(2)) u_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (fx_data),
        .in_valid  (fx_valid),
        .in_ready  (fx_ready),
        .out_data  (fx_odata),
        .out_ch    (fx_och),
        .out_valid (fx_ovalid),
        .out_ready (fx_oready),
        .hold      (fx_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source-side rule: a pending (valid, not accepted) word must not change
    logic [3:0]  prev_pend;
    logic [31:0] prev_word [4];
    always @(posedge clk) begin
        if (!rst_n) begin
            prev_pend <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (prev_pend[c] && rr_valid[c])
                    assert (rr_data[c*32 +: 32] == prev_word[c])
                    else $error("source changed pending word on ch%0d", c);
                prev_word[c] <= rr_data[c*32 +: 32];
            end
            prev_pend <= rr_valid & ~rr_ready;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        rr_valid  = 4'b1111;
        rr_oready = 1'b1;
        rr_hold   = 1'b0;
        fx_valid  = 4'b1111;
        fx_oready = 1'b1;
        fx_hold   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rr_data[c*32 +: 32] = 32'hA0 + c;
            fx_data[c*32 +: 32] = 32'hB0 + c;
        end

        // Reset state with every channel requesting
        #1;
        check("rst_ovalid", {31'd0, rr_ovalid}, 32'd0);
        check("rst_odata", rr_odata, 32'd0);
        check("rst_och", {30'd0, rr_och}, 32'd0);
        check("rst_inready", {28'd0, rr_ready}, 32'd0);
        check("rst_fx_inready", {28'd0, fx_ready}, 32'd0);
        tick();
        check("rst_edge_ovalid", {31'd0, rr_ovalid}, 32'd0);
        check("rst_edge_fx_ovalid", {31'd0, fx_ovalid}, 32'd0);
        fx_valid = 4'b0000;
        rst_n    = 1'b1;

        //              valid    ordy  hold  ready    ov    ch     data
        tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA0}); // first grant ch0
        tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA1});
        tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA2});
        tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA3});
        tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA0}); // wrap back to ch0
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 32'hA0}); // idle: data holds
        tbl.push_back('{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA2}); // single requester, ptr=1
        tbl.push_back('{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA3}); // ptr=3
        tbl.push_back('{4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA0}); // wrapped ptr=0
        tbl.push_back('{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 32'hA2}); // ptr -> 3
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3}); // hold keeps ptr=3
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3});
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3});
        tbl.push_back('{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hA3}); // release hold
        tbl.push_back('{4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA0}); // ptr=1 after
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0}); // stall
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA0});
        tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA1}); // drain+load, ptr=2

        foreach (tbl[i]) begin
            rr_valid  = tbl[i].valid;
            rr_oready = tbl[i].oready;
            rr_hold   = tbl[i].hold;
            #1;
            check($sformatf("v%0d_inready", i), {28'd0, rr_ready}, {28'd0, tbl[i].exp_ready});
            tick();
            check($sformatf("v%0d_ovalid", i), {31'd0, rr_ovalid}, {31'd0, tbl[i].exp_ovalid});
            check($sformatf("v%0d_odata", i), rr_odata, tbl[i].exp_data);
            if (tbl[i].exp_ovalid)
                check($sformatf("v%0d_och", i), {30'd0, rr_och}, {30'd0, tbl[i].exp_ch});
        end

        // Back-pressure with a distinctive word, then drain+load with no bubble
        rr_valid = 4'b0000;
        tick();
        rr_data[31:0] = 32'hDEADBEEF;
        rr_valid = 4'b0001;
        #1;
        check("bp_load_inready", {28'd0, rr_ready}, 32'h1);
        tick();
        check("bp_load_odata", rr_odata, 32'hDEADBEEF);
        rr_data[31:0] = 32'h12345678;
        rr_oready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check($sformatf("bp_stall%0d_inready", s), {28'd0, rr_ready}, 32'h0);
            tick();
            check($sformatf("bp_stall%0d_odata", s), rr_odata, 32'hDEADBEEF);
            check($sformatf("bp_stall%0d_ovalid", s), {31'd0, rr_ovalid}, 32'h1);
        end
        rr_oready = 1'b1;
        #1;
        check("bp_release_inready", {28'd0, rr_ready}, 32'h1);
        tick();
        check("bp_release_odata", rr_odata, 32'h12345678);
        check("bp_release_ovalid", {31'd0, rr_ovalid}, 32'h1);

        // Reset mid-stream: ptr=1 here, so ch1 is loaded, then rst_n drops between edges
        rr_valid = 4'b1111;
        tick();
        check("mid_pre_och", {30'd0, rr_och}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_ovalid", {31'd0, rr_ovalid}, 32'h0);
        check("mid_async_odata", rr_odata, 32'h0);
        check("mid_async_inready", {28'd0, rr_ready}, 32'h0);
        tick();
        check("mid_edge_ovalid", {31'd0, rr_ovalid}, 32'h0);
        check("mid_edge_inready", {28'd0, rr_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("mid_post_inready", {28'd0, rr_ready}, 32'h1);
        tick();
        check("mid_post_och", {30'd0, rr_och}, 32'h0);
        check("mid_post_odata", rr_odata, 32'h12345678);

        // Fixed priority: ch1 always beats ch3
        fx_valid = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            #1;
            check($sformatf("fx%0d_inready", s), {28'd0, fx_ready}, 32'h2);
            tick();
            check($sformatf("fx%0d_och", s), {30'd0, fx_och}, 32'h1);
            check($sformatf("fx%0d_odata", s), fx_odata, 32'hB1);
        end
        fx_valid = 4'b1000;
        #1;
        check("fx_ch3_inready", {28'd0, fx_ready}, 32'h8);
        tick();
        check("fx_ch3_och", {30'd0, fx_och}, 32'h3);
        check("fx_ch3_odata", fx_odata, 32'hB3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
